fft_sequencer: RTL and testbench
================================

// Module: fft_sequencer
// PURPOSE
//  In-place radix-2 DIT FFT controller that drives the combinational radix-2 butterfly.
//  Each cycle it reads an operand pair from a dual-port sample RAM and a twiddle from ROM,
//  presents them to the butterfly, and writes both results back to the same addresses.
//  It walks all log2(N) stages, then pulses done. Sits between the sample RAM (loaded in
//  bit-reversed order by the capture block) and the peak/pitch detector.
// PARAMETERS
//  WIDTH   16  signed sample/twiddle width, Q1.(WIDTH-1) fixed point
//  N_LOG2   9  log2 of FFT length N (N=512); legal range 2..12
//  SCALE    1  1: arithmetic >>>1 on butterfly results before write-back; 0: no scaling
// PORTS
//  clk           in   1          clock, rising edge
//  rst_n         in   1          asynchronous reset, active-low
//  start         in   1          1-cycle request; sampled only in IDLE
//  busy          out  1          high from cycle after accepted start through done cycle
//  done          out  1          1-cycle pulse when last write of last stage has retired
//  rd_en         out  1          RAM read strobe, both ports
//  rd_addr_a     out  N_LOG2     port A read address
//  rd_addr_b     out  N_LOG2     port B read address
//  rd_data_a     in   2*WIDTH    {imag,real}; valid 1 cycle after rd_en
//  rd_data_b     in   2*WIDTH    {imag,real}; valid 1 cycle after rd_en
//  tw_addr       out  N_LOG2-1   twiddle ROM index; data valid 1 cycle later
//  tw_data       in   2*WIDTH    {imag,real} of W_N^k = exp(-j2*pi*k/N)
//  bf_a_*/bf_b_*/bf_tw_*  out WIDTH each (real,imag)  operands to the butterfly, wired from rd_data/tw_data
//  bf_out1_*/bf_out2_*    in  WIDTH each (real,imag)  butterfly results
//  wr_en         out  1          RAM write strobe, both ports
//  wr_addr_a     out  N_LOG2     destination of out1
//  wr_addr_b     out  N_LOG2     destination of out2
//  wr_data_a     out  2*WIDTH    {imag,real} of out1 (scaled per SCALE)
//  wr_data_b     out  2*WIDTH    {imag,real} of out2 (scaled per SCALE)
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, rd_en, wr_en = 0; all address, write-data and pipeline
//   registers = 0.
//  FSM: IDLE -start-> RUN; RUN issues one butterfly/cycle, j = 0..N/2-1; after j=N/2-1 -> DRAIN
//   (2 cycles, no reads); DRAIN end: s<N_LOG2-1 -> s++, j=0, RUN; else -> DONE (done=1, 1 cycle)
//   -> IDLE.
//  Addressing, stage s, butterfly j: half=1<<s; k=j&(half-1); a=((j>>s)<<(s+1))|k; b=a+half;
//   tw_addr=k<<(N_LOG2-1-s).
//  Pipeline: T0 rd_en, rd_addr_a/b, tw_addr registered out; T1 rd/tw data valid, butterfly
//   combinational, results and addresses captured; T2 wr_en, wr_addr_a/b, wr_data_a/b
//   registered out. Latency is 2 cycles, issue rate 1/cycle.
//  DRAIN guarantees stage s writes retire before stage s+1 reads, so no RAW hazard.
//  Total busy cycles = N_LOG2*(N/2+2)+1.
//  Arithmetic: SCALE=1 -> wr_data = bf_out >>> 1, sign-preserved and truncated.
//   SCALE=0 -> bf_out passed through; overflow wraps, no saturation.
//  start while busy: ignored, no restart. start in DONE cycle: ignored.
//  rst_n low mid-operation: immediate return to IDLE, no done pulse, RAM contents undefined.
//  wr_en never asserted outside RUN/DRAIN; rd_en never asserted in DRAIN/DONE/IDLE.
// STRUCTURE
//  fft_pkg: state encoding (IDLE/RUN/DRAIN/DONE), PIPE_DEPTH=2, {imag,real} pack/unpack functions.
//  Sub-module fft_addr_gen: combinational (s,j) -> (addr_a, addr_b, tw_addr).
//  Top module holds the FSM, stage/index counters and T1/T2 pipeline registers.
// TESTING  (N_LOG2=3, WIDTH=16, bit-reversed RAM preload, ideal ROM/RAM models, real butterfly)
//  Impulse x[0]=0x2000, rest 0, SCALE=1 -> all 8 bins real=0x0400, imag=0; done after 19 busy cycles.
//  DC x[n]=0x1000 all n, SCALE=1 -> bin0 real=0x1000, bins 1..7 = 0 (within +-1 LSB).
//  Stage 1 trace -> addr pairs (0,2),(1,3),(4,6),(5,7), tw_addr 0,2,0,2; stage 2 pairs (0,4)..(3,7), tw 0,1,2,3.
//  Write-after-read check: each wr_addr equals rd_addr from exactly 2 cycles earlier; no read in DRAIN.
//  start pulsed at busy cycle 5 -> ignored, total cycles unchanged, single done pulse.
//  rst_n low at stage 1, j=2 -> busy/rd_en/wr_en low immediately, no done; a fresh start completes normally.

Source files
------------

// File: rtl/fft_pkg.sv
//==============================================================================
// Module   : fft_pkg
// Brief    : Shared state encoding, pipeline depth and {imag,real} helpers
//            for the in-place radix-2 FFT sequencer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package fft_pkg;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam int PIPE_DEPTH = 2;

    // Helpers work on a 32-bit maximum lane; callers size-cast to their WIDTH.
    localparam int c_MAXW  = 32;
    localparam int c_MAXW2 = 2 * c_MAXW;

    function automatic logic [c_MAXW2-1:0] low_mask(input int unsigned w);
        return {c_MAXW2{1'b1}} >> (c_MAXW2 - w);
    endfunction

    function automatic logic [c_MAXW2-1:0] cplx_pack(input logic [c_MAXW-1:0] re,
                                                     input logic [c_MAXW-1:0] im,
                                                     input int unsigned       w);
        return ({{c_MAXW{1'b0}}, im} << w) | ({{c_MAXW{1'b0}}, re} & low_mask(w));
    endfunction

    function automatic logic [c_MAXW-1:0] cplx_re(input logic [c_MAXW2-1:0] d,
                                                  input int unsigned      w);
        return c_MAXW'(d & low_mask(w));
    endfunction

    function automatic logic [c_MAXW-1:0] cplx_im(input logic [c_MAXW2-1:0] d,
                                                  input int unsigned      w);
        return c_MAXW'(d >> w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fft_addr_gen.sv
//==============================================================================
// Module   : fft_addr_gen
// Brief    : Combinational (stage, butterfly) -> (addr_a, addr_b, tw_addr).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fft_addr_gen #(
    parameter int N_LOG2 = 9,
    parameter int SW     = 4
) (
    input  logic [SW-1:0]     i_stage,
    input  logic [N_LOG2-2:0] i_j,
    output logic [N_LOG2-1:0] o_addr_a,
    output logic [N_LOG2-1:0] o_addr_b,
    output logic [N_LOG2-2:0] o_tw_addr
);

    logic [N_LOG2-1:0] w_half;
    logic [N_LOG2-1:0] w_j;
    logic [N_LOG2-1:0] w_k;
    logic [N_LOG2-1:0] w_a;

    assign w_j    = {1'b0, i_j};
    assign w_half = N_LOG2'(1) << i_stage;
    assign w_k    = w_j & (w_half - N_LOG2'(1));
    // Insert a zero at bit position s of j to form the lower operand index.
    assign w_a    = ((w_j >> i_stage) << (int'(i_stage) + 1)) | w_k;

    assign o_addr_a  = w_a;
    assign o_addr_b  = w_a | w_half;
    assign o_tw_addr = (N_LOG2-1)'(w_k << (N_LOG2 - 1 - int'(i_stage)));

endmodule

`default_nettype wire

// File: rtl/fft_sequencer.sv
//==============================================================================
// Module   : fft_sequencer
// Brief    : In-place radix-2 DIT FFT controller: issues one butterfly per cycle
//            over all stages with a 2-cycle read/compute/write pipeline.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fft_sequencer
    import fft_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int N_LOG2 = 9,
    parameter int SCALE  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [N_LOG2-1:0]       rd_addr_a,
    output logic [N_LOG2-1:0]       rd_addr_b,
    input  logic [2*WIDTH-1:0]      rd_data_a,
    input  logic [2*WIDTH-1:0]      rd_data_b,
    output logic [N_LOG2-2:0]       tw_addr,
    input  logic [2*WIDTH-1:0]      tw_data,
    output logic [WIDTH-1:0]        bf_a_real,
    output logic [WIDTH-1:0]        bf_a_imag,
    output logic [WIDTH-1:0]        bf_b_real,
    output logic [WIDTH-1:0]        bf_b_imag,
    output logic [WIDTH-1:0]        bf_tw_real,
    output logic [WIDTH-1:0]        bf_tw_imag,
    input  logic signed [WIDTH-1:0] bf_out1_real,
    input  logic signed [WIDTH-1:0] bf_out1_imag,
    input  logic signed [WIDTH-1:0] bf_out2_real,
    input  logic signed [WIDTH-1:0] bf_out2_imag,
    output logic                    wr_en,
    output logic [N_LOG2-1:0]       wr_addr_a,
    output logic [N_LOG2-1:0]       wr_addr_b,
    output logic [2*WIDTH-1:0]      wr_data_a,
    output logic [2*WIDTH-1:0]      wr_data_b
);

    localparam int              c_SW     = $clog2(N_LOG2);
    localparam int              c_JW     = N_LOG2 - 1;
    localparam int              c_CW     = 2 * WIDTH;
    localparam logic [c_JW-1:0] c_LAST_J = '1;
    localparam logic [c_SW-1:0] c_LAST_S = c_SW'(N_LOG2 - 1);

    logic [1:0]              r_state;
    logic [1:0]              w_nxt_state;
    logic [c_SW-1:0]         r_stage;
    logic [c_SW-1:0]         w_nxt_stage;
    logic [c_JW-1:0]         r_j;
    logic [c_JW-1:0]         w_nxt_j;
    logic                    r_drain_cnt;
    logic                    w_nxt_drain_cnt;
    logic                    w_issue;

    logic [N_LOG2-1:0]       w_gen_a;
    logic [N_LOG2-1:0]       w_gen_b;
    logic [N_LOG2-2:0]       w_gen_tw;

    logic                    r_rd_en;
    logic [N_LOG2-1:0]       r_rd_addr_a;
    logic [N_LOG2-1:0]       r_rd_addr_b;
    logic [N_LOG2-2:0]       r_tw_addr;

    logic [PIPE_DEPTH-1:0]   r_pipe_vld;
    logic [N_LOG2-1:0]       r_t1_addr_a;
    logic [N_LOG2-1:0]       r_t1_addr_b;
    logic [N_LOG2-1:0]       r_wr_addr_a;
    logic [N_LOG2-1:0]       r_wr_addr_b;
    logic [c_CW-1:0]         r_wr_data_a;
    logic [c_CW-1:0]         r_wr_data_b;

    logic signed [WIDTH-1:0] w_o1r;
    logic signed [WIDTH-1:0] w_o1i;
    logic signed [WIDTH-1:0] w_o2r;
    logic signed [WIDTH-1:0] w_o2i;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_stage     <= '0;
            r_j         <= '0;
            r_drain_cnt <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_stage     <= w_nxt_stage;
            r_j         <= w_nxt_j;
            r_drain_cnt <= w_nxt_drain_cnt;
        end
    end

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_stage     = r_stage;
        w_nxt_j         = r_j;
        w_nxt_drain_cnt = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_nxt_state = c_RUN;
                    w_nxt_stage = '0;
                    w_nxt_j     = '0;
                end
            end
            c_RUN: begin
                if (r_j == c_LAST_J) begin
                    w_nxt_state = c_DRAIN;
                end else begin
                    w_nxt_j = r_j + c_JW'(1);
                end
            end
            c_DRAIN: begin
                // Two drain cycles let the last writes of a stage retire first.
                if (r_drain_cnt) begin
                    if (r_stage == c_LAST_S) begin
                        w_nxt_state = c_DONE;
                    end else begin
                        w_nxt_state = c_RUN;
                        w_nxt_stage = r_stage + c_SW'(1);
                        w_nxt_j     = '0;
                    end
                end else begin
                    w_nxt_drain_cnt = 1'b1;
                end
            end
            c_DONE: begin
                w_nxt_state = c_IDLE;
            end
            default: begin
                w_nxt_state = c_IDLE;
            end
        endcase
    end

    always_comb begin
        busy    = (r_state != c_IDLE);
        done    = (r_state == c_DONE);
        w_issue = (w_nxt_state == c_RUN);
    end

    // ---------------------------------------------------------------- T0
    // Addresses come from the next-state counters so the registered read
    // strobe lines up exactly with the RUN cycles.
    fft_addr_gen #(
        .N_LOG2 (N_LOG2),
        .SW     (c_SW)
    ) u_addr_gen (
        .i_stage   (w_nxt_stage),
        .i_j       (w_nxt_j),
        .o_addr_a  (w_gen_a),
        .o_addr_b  (w_gen_b),
        .o_tw_addr (w_gen_tw)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_en     <= 1'b0;
            r_rd_addr_a <= '0;
            r_rd_addr_b <= '0;
            r_tw_addr   <= '0;
        end else begin
            r_rd_en <= w_issue;
            if (w_issue) begin
                r_rd_addr_a <= w_gen_a;
                r_rd_addr_b <= w_gen_b;
                r_tw_addr   <= w_gen_tw;
            end
        end
    end

    // ---------------------------------------------------------------- T1
    assign bf_a_real  = WIDTH'(cplx_re(c_MAXW2'(rd_data_a), WIDTH));
    assign bf_a_imag  = WIDTH'(cplx_im(c_MAXW2'(rd_data_a), WIDTH));
    assign bf_b_real  = WIDTH'(cplx_re(c_MAXW2'(rd_data_b), WIDTH));
    assign bf_b_imag  = WIDTH'(cplx_im(c_MAXW2'(rd_data_b), WIDTH));
    assign bf_tw_real = WIDTH'(cplx_re(c_MAXW2'(tw_data), WIDTH));
    assign bf_tw_imag = WIDTH'(cplx_im(c_MAXW2'(tw_data), WIDTH));

    if (SCALE != 0) begin : g_scale
        assign w_o1r = bf_out1_real >>> 1;
        assign w_o1i = bf_out1_imag >>> 1;
        assign w_o2r = bf_out2_real >>> 1;
        assign w_o2i = bf_out2_imag >>> 1;
    end else begin : g_pass
        assign w_o1r = bf_out1_real;
        assign w_o1i = bf_out1_imag;
        assign w_o2r = bf_out2_real;
        assign w_o2i = bf_out2_imag;
    end

    // ---------------------------------------------------------------- T1/T2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld  <= '0;
            r_t1_addr_a <= '0;
            r_t1_addr_b <= '0;
            r_wr_addr_a <= '0;
            r_wr_addr_b <= '0;
            r_wr_data_a <= '0;
            r_wr_data_b <= '0;
        end else begin
            r_pipe_vld <= {r_pipe_vld[PIPE_DEPTH-2:0], r_rd_en};
            if (r_rd_en) begin
                r_t1_addr_a <= r_rd_addr_a;
                r_t1_addr_b <= r_rd_addr_b;
            end
            if (r_pipe_vld[0]) begin
                r_wr_addr_a <= r_t1_addr_a;
                r_wr_addr_b <= r_t1_addr_b;
                r_wr_data_a <= c_CW'(cplx_pack(c_MAXW'(w_o1r), c_MAXW'(w_o1i), WIDTH));
                r_wr_data_b <= c_CW'(cplx_pack(c_MAXW'(w_o2r), c_MAXW'(w_o2i), WIDTH));
            end
        end
    end

    assign rd_en     = r_rd_en;
    assign rd_addr_a = r_rd_addr_a;
    assign rd_addr_b = r_rd_addr_b;
    assign tw_addr   = r_tw_addr;
    assign wr_en     = r_pipe_vld[PIPE_DEPTH-1];
    assign wr_addr_a = r_wr_addr_a;
    assign wr_addr_b = r_wr_addr_b;
    assign wr_data_a = r_wr_data_a;
    assign wr_data_b = r_wr_data_b;

endmodule

`default_nettype wire

// File: tb/tb_fft_sequencer.sv
//==============================================================================
// Module   : tb_fft_sequencer
// Brief    : Self-checking bench: 8-point FFT with RAM/ROM/butterfly models.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fft_sequencer;
    import fft_pkg::*;

    localparam int WIDTH  = 16;
    localparam int N_LOG2 = 3;
    localparam int N      = 8;
    localparam int HALF   = N / 2;
    localparam int PER    = HALF + PIPE_DEPTH;
    localparam int TOTAL  = N_LOG2 * PER + 1;

    logic                    clk;
    logic                    rst_n;
    logic                    start;
    logic                    busy, done, rd_en, wr_en;
    logic [N_LOG2-1:0]       rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [N_LOG2-2:0]       tw_addr;
    logic [2*WIDTH-1:0]      rd_data_a, rd_data_b, tw_data, wr_data_a, wr_data_b;
    logic [WIDTH-1:0]        bf_a_real, bf_a_imag, bf_b_real, bf_b_imag, bf_tw_real, bf_tw_imag;
    logic signed [WIDTH-1:0] bf_out1_real, bf_out1_imag, bf_out2_real, bf_out2_imag;

    logic                    ld_en;
    logic [N_LOG2-1:0]       ld_addr;
    logic [31:0]             ld_data;
    logic [31:0]             ram [N];
    logic [31:0]             rom [HALF];
    logic [31:0]             x_in [N];
    logic [31:0]             y_ref [N];

    int n_vec = 0;
    int n_err = 0;

    int exp_a  [N_LOG2][HALF] = '{'{0, 2, 4, 6}, '{0, 1, 4, 5}, '{0, 1, 2, 3}};
    int exp_b  [N_LOG2][HALF] = '{'{1, 3, 5, 7}, '{2, 3, 6, 7}, '{4, 5, 6, 7}};
    int exp_tw [N_LOG2][HALF] = '{'{0, 0, 0, 0}, '{0, 2, 0, 2}, '{0, 1, 2, 3}};

    fft_sequencer #(
        .WIDTH  (WIDTH),
        .N_LOG2 (N_LOG2),
        .SCALE  (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .rd_en        (rd_en),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .rd_data_a    (rd_data_a),
        .rd_data_b    (rd_data_b),
        .tw_addr      (tw_addr),
        .tw_data      (tw_data),
        .bf_a_real    (bf_a_real),
        .bf_a_imag    (bf_a_imag),
        .bf_b_real    (bf_b_real),
        .bf_b_imag    (bf_b_imag),
        .bf_tw_real   (bf_tw_real),
        .bf_tw_imag   (bf_tw_imag),
        .bf_out1_real (bf_out1_real),
        .bf_out1_imag (bf_out1_imag),
        .bf_out2_real (bf_out2_real),
        .bf_out2_imag (bf_out2_imag),
        .wr_en        (wr_en),
        .wr_addr_a    (wr_addr_a),
        .wr_addr_b    (wr_addr_b),
        .wr_data_a    (wr_data_a),
        .wr_data_b    (wr_data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Q1.15 butterfly with round-to-nearest products; returns {o2i,o2r,o1i,o1r}.
    function automatic logic [63:0] bfly(input logic signed [15:0] ar, ai, br, bi, wr, wi);
        longint pr, pi;
        logic signed [15:0] tr, ti;
        pr = (longint'(br) * longint'(wr) - longint'(bi) * longint'(wi) + 16384) >>> 15;
        pi = (longint'(br) * longint'(wi) + longint'(bi) * longint'(wr) + 16384) >>> 15;
        tr = pr[15:0];
        ti = pi[15:0];
        return {16'(ai - ti), 16'(ar - tr), 16'(ai + ti), 16'(ar + tr)};
    endfunction

    function automatic logic [15:0] half_of(input logic signed [15:0] v);
        return v >>> 1;
    endfunction

    function automatic int bitrev(input int n);
        return ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
    endfunction

    assign {bf_out2_imag, bf_out2_real, bf_out1_imag, bf_out1_real} =
        bfly(bf_a_real, bf_a_imag, bf_b_real, bf_b_imag, bf_tw_real, bf_tw_imag);

    always @(posedge clk) begin
        if (ld_en) ram[ld_addr] <= ld_data;
        if (rd_en) begin
            rd_data_a <= ram[rd_addr_a];
            rd_data_b <= ram[rd_addr_b];
        end
        tw_data <= rom[tw_addr];
        if (wr_en) begin
            ram[wr_addr_a] <= wr_data_a;
            ram[wr_addr_b] <= wr_data_b;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Textbook in-place DIT FFT on bit-reversed input, halving after each stage.
    task automatic compute_ref();
        logic [63:0] r;
        logic [31:0] tw;
        for (int n = 0; n < N; n++) y_ref[bitrev(n)] = x_in[n];
        for (int m = 2; m <= N; m *= 2) begin
            for (int g = 0; g < N; g += m) begin
                for (int k = 0; k < m / 2; k++) begin
                    tw = rom[k * (N / m)];
                    r  = bfly(y_ref[g+k][15:0], y_ref[g+k][31:16],
                              y_ref[g+k+m/2][15:0], y_ref[g+k+m/2][31:16], tw[15:0], tw[31:16]);
                    y_ref[g+k]     = {half_of(r[31:16]), half_of(r[15:0])};
                    y_ref[g+k+m/2] = {half_of(r[63:48]), half_of(r[47:32])};
                end
            end
        end
    endtask

    task automatic run_fft(input string tag, input int glitch_at, input int rst_at);
        int idx, dones, s, ph;
        int hist_a [TOTAL];
        int hist_b [TOTAL];
        for (int n = 0; n < N; n++) begin
            @(negedge clk);
            ld_en   = 1'b1;
            ld_addr = N_LOG2'(bitrev(n));
            ld_data = x_in[n];
        end
        @(negedge clk);
        ld_en = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx   = 0;
        dones = 0;
        for (int cyc = 0; cyc < TOTAL + 20; cyc++) begin
            if (!busy) break;
            s  = idx / PER;
            ph = idx % PER;
            check($sformatf("%s rd_en@%0d", tag, idx), rd_en, (s < N_LOG2) && (ph < HALF));
            check($sformatf("%s wr_en@%0d", tag, idx), wr_en, (s < N_LOG2) && (ph >= PIPE_DEPTH));
            check($sformatf("%s done@%0d", tag, idx), done, idx == TOTAL - 1);
            if (done) dones++;
            if (idx < TOTAL) begin
                hist_a[idx] = int'(rd_addr_a);
                hist_b[idx] = int'(rd_addr_b);
            end
            if (rd_en && s < N_LOG2 && ph < HALF) begin
                check($sformatf("%s addr_a s%0d j%0d", tag, s, ph), rd_addr_a, exp_a[s][ph]);
                check($sformatf("%s addr_b s%0d j%0d", tag, s, ph), rd_addr_b, exp_b[s][ph]);
                check($sformatf("%s tw s%0d j%0d", tag, s, ph), tw_addr, exp_tw[s][ph]);
            end
            if (wr_en && idx >= PIPE_DEPTH && idx < TOTAL) begin
                check($sformatf("%s war_a@%0d", tag, idx), wr_addr_a, hist_a[idx-PIPE_DEPTH]);
                check($sformatf("%s war_b@%0d", tag, idx), wr_addr_b, hist_b[idx-PIPE_DEPTH]);
            end
            if (idx == rst_at) begin
                rst_n = 1'b0;
                #1;
                check({tag, " rst busy"}, busy, 0);
                check({tag, " rst rd_en"}, rd_en, 0);
                check({tag, " rst wr_en"}, wr_en, 0);
                check({tag, " rst done"}, done, 0);
                @(negedge clk);
                check({tag, " rst done2"}, done, 0);
                check({tag, " rst busy2"}, busy, 0);
                rst_n = 1'b1;
                start = 1'b0;
                @(negedge clk);
                return;
            end
            start = (idx == glitch_at);
            idx++;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " busy cycles"}, idx, TOTAL);
        check({tag, " done pulses"}, dones, 1);
    endtask

    task automatic check_vs_ref(input string tag);
        compute_ref();
        for (int k = 0; k < N; k++)
            check($sformatf("%s bin%0d", tag, k), ram[k], y_ref[k]);
    endtask

    task automatic load_random();
        for (int n = 0; n < N; n++)
            x_in[n] = {16'($urandom_range(0, 32767) - 16384), 16'($urandom_range(0, 32767) - 16384)};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        rst_n   = 1'b0;
        start   = 1'b0;
        ld_en   = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        rom[0] = {16'sd0,      16'sd32767};
        rom[1] = {-16'sd23170, 16'sd23170};
        rom[2] = {-16'sd32767, 16'sd0};
        rom[3] = {-16'sd23170, -16'sd23170};

        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset rd_en", rd_en, 0);
        check("reset wr_en", wr_en, 0);
        check("reset rd_addr_a", rd_addr_a, 0);
        check("reset tw_addr", tw_addr, 0);
        check("reset wr_addr_b", wr_addr_b, 0);
        check("reset wr_data_a", wr_data_a, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int n = 0; n < N; n++) x_in[n] = '0;
        x_in[0] = 32'h0000_2000;
        run_fft("impulse", -1, -1);
        for (int k = 0; k < N; k++)
            check($sformatf("impulse const bin%0d", k), ram[k], 32'h0000_0400);
        check_vs_ref("impulse");

        for (int n = 0; n < N; n++) x_in[n] = 32'h0000_1000;
        run_fft("dc", -1, -1);
        for (int k = 0; k < N; k++) begin
            d = int'($signed(ram[k][15:0])) - ((k == 0) ? 32'sh1000 : 0);
            check($sformatf("dc re bin%0d within 1", k), (d >= -1 && d <= 1), 1);
            d = int'($signed(ram[k][31:16]));
            check($sformatf("dc im bin%0d within 1", k), (d >= -1 && d <= 1), 1);
        end
        check_vs_ref("dc");

        for (int t = 0; t < 3; t++) begin
            load_random();
            run_fft($sformatf("rand%0d", t), (t == 1) ? 5 : -1, -1);
            check_vs_ref($sformatf("rand%0d", t));
        end

        load_random();
        run_fft("abort", -1, PER + 2);

        load_random();
        run_fft("after_abort", -1, -1);
        check_vs_ref("after_abort");

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
